// File: rtl/rsa_avmm_host_if.sv
// Avalon-MM bus bundle between the RSA job host (master) and the RSA peripheral (slave).
interface rsa_avmm_host_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/rsa_avmm_host.sv
// Avalon-MM master running one RSA job per go pulse: start, poll done, read results.
// All outputs, including bus command signals, come straight from flops.
module rsa_avmm_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              job_done,
  output logic              timeout_err,
  output logic [DATA_W-1:0] e_out,
  output logic [DATA_W-1:0] d_out,
  output logic [DATA_W-1:0] n_out,
  output logic [DATA_W-1:0] cipher_out,
  output logic [DATA_W-1:0] plain_out,
  rsa_avmm_host_if.master   avm
);
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WR_SET = 4'd1;
  localparam logic [3:0] S_WR_CLR = 4'd2;
  localparam logic [3:0] S_POLL   = 4'd3;
  localparam logic [3:0] S_RD_E   = 4'd4;
  localparam logic [3:0] S_RD_D   = 4'd5;
  localparam logic [3:0] S_RD_N   = 4'd6;
  localparam logic [3:0] S_RD_C   = 4'd7;
  localparam logic [3:0] S_RD_P   = 4'd8;
  localparam logic [3:0] S_FINISH = 4'd9;
  localparam logic [3:0] S_ERR    = 4'd10;

  logic [3:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] e_q, e_d, d_q, d_d, n_q, n_d, c_q, c_d, p_q, p_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              xfer_ok;

  assign xfer_ok = !avm.avm_waitrequest;

  // Next state, timeout counter, error flag and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    e_d     = e_q;
    d_d     = d_q;
    n_d     = n_q;
    c_d     = c_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_WR_SET;
        end
      end
      S_WR_SET: if (xfer_ok) state_d = S_WR_CLR;
      S_WR_CLR: if (xfer_ok) state_d = S_POLL;
      S_POLL: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // A done seen on the last allowed poll still wins over the timeout
        if (xfer_ok && avm.avm_readdata[0]) state_d = S_RD_E;
        else if (cnt_q == CNT_LAST)         state_d = S_ERR;
      end
      S_RD_E: if (xfer_ok) begin e_d = avm.avm_readdata; state_d = S_RD_D; end
      S_RD_D: if (xfer_ok) begin d_d = avm.avm_readdata; state_d = S_RD_N; end
      S_RD_N: if (xfer_ok) begin n_d = avm.avm_readdata; state_d = S_RD_C; end
      S_RD_C: if (xfer_ok) begin c_d = avm.avm_readdata; state_d = S_RD_P; end
      S_RD_P: if (xfer_ok) begin p_d = avm.avm_readdata; state_d = S_FINISH; end
      S_FINISH: state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Bus command and status for the state being entered, so they are registered
  always_comb begin
    addr_d  = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH) || (state_d == S_ERR);
    case (state_d)
      S_WR_SET: begin wr_d = 1'b1; addr_d = ADDR_W'(0); wdata_d = DATA_W'(1); end
      S_WR_CLR: begin wr_d = 1'b1; addr_d = ADDR_W'(0); end
      S_POLL:   begin rd_d = 1'b1; addr_d = ADDR_W'(6); end
      S_RD_E:   begin rd_d = 1'b1; addr_d = ADDR_W'(1); end
      S_RD_D:   begin rd_d = 1'b1; addr_d = ADDR_W'(2); end
      S_RD_N:   begin rd_d = 1'b1; addr_d = ADDR_W'(3); end
      S_RD_C:   begin rd_d = 1'b1; addr_d = ADDR_W'(4); end
      S_RD_P:   begin rd_d = 1'b1; addr_d = ADDR_W'(5); end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      e_q     <= e_d;
      d_q     <= d_d;
      n_q     <= n_d;
      c_q     <= c_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy              = busy_q;
  assign job_done          = done_q;
  assign timeout_err       = err_q;
  assign e_out             = e_q;
  assign d_out             = d_q;
  assign n_out             = n_q;
  assign cipher_out        = c_q;
  assign plain_out         = p_q;
  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = rd_q;
  assign avm.avm_write     = wr_q;
  assign avm.avm_writedata = wdata_q;
endmodule

// File: tb/tb_rsa_avmm_host.sv
// Bench for rsa_avmm_host: behavioural RSA peripheral, bus monitor and directed/random jobs.
module tb_rsa_avmm_host;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        busy, job_done, timeout_err;
  logic [31:0] e_out, d_out, n_out, cipher_out, plain_out;

  rsa_avmm_host_if bus ();

  rsa_avmm_host #(.TIMEOUT_CYCLES(TO), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .job_done(job_done),
    .timeout_err(timeout_err), .e_out(e_out), .d_out(d_out), .n_out(n_out),
    .cipher_out(cipher_out), .plain_out(plain_out), .avm(bus)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; int addr; logic [31:0] data; } txn_t;

  // Peripheral model state
  logic [31:0] m_e, m_d, m_n, m_c, m_p;
  int          done_poll = 0;   // done pulses on this POLL cycle of the job (0 = never)
  bit          stall_en = 1'b0;
  int          stall_addr = 31; // reads of this address stall forever
  int          poll_cnt = 0;
  bit          done_now = 1'b0;

  // Monitor state
  txn_t log_q[$];
  int   jd_cnt = 0, overlap_cnt = 0, unstable_cnt = 0;
  int   n_asrt = 0, n_fail = 0;

  always_comb begin
    bus.avm_readdata = 32'd0;
    case (bus.avm_address)
      5'd1: bus.avm_readdata = m_e;
      5'd2: bus.avm_readdata = m_d;
      5'd3: bus.avm_readdata = m_n;
      5'd4: bus.avm_readdata = m_c;
      5'd5: bus.avm_readdata = m_p;
      5'd6: bus.avm_readdata = {31'd0, done_now};
      default: bus.avm_readdata = 32'd0;
    endcase
  end

  // Slave response: waitrequest and the one-cycle done flag, decided just after each edge
  initial begin
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #2;
      done_now = bus.avm_read && bus.avm_address == 5'd6 && done_poll != 0
                 && (poll_cnt + 1 == done_poll);
      if (bus.avm_read && int'(bus.avm_address) == stall_addr) bus.avm_waitrequest = 1'b1;
      else if (done_now || !stall_en || reset)                  bus.avm_waitrequest = 1'b0;
      else bus.avm_waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // Bus monitor: transaction log, stall stability, overlap, job_done pulses
  initial begin
    logic [38:0] cmd, prev_cmd;
    bit          prev_stall;
    txn_t        t;
    prev_stall = 1'b0;
    prev_cmd   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        poll_cnt   = 0;
      end else begin
        cmd = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
        if (prev_stall && cmd != prev_cmd) unstable_cnt++;
        if (bus.avm_read && bus.avm_write) overlap_cnt++;
        if (job_done) jd_cnt++;
        if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
          t.wr   = bus.avm_write;
          t.addr = int'(bus.avm_address);
          t.data = bus.avm_write ? bus.avm_writedata : bus.avm_readdata;
          log_q.push_back(t);
          if (bus.avm_write && bus.avm_address == 5'd0 && bus.avm_writedata[0]) poll_cnt = 0;
        end
        if (bus.avm_read && bus.avm_address == 5'd6) poll_cnt++;
        prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
        prev_cmd   = cmd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modpow(input int b, input int e, input int m);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return 32'(r);
  endfunction

  // Textbook RSA with P=3, Q=5, message 5, e=17
  task automatic load_rsa();
    int n, phi, dd;
    n = 3 * 5; phi = 2 * 4; dd = 0;
    for (int i = 1; i <= phi && dd == 0; i++) if ((17 * i) % phi == 1) dd = i;
    m_e = 32'd17; m_d = 32'(dd); m_n = 32'(n);
    m_c = modpow(5, 17, n);
    m_p = modpow(int'(m_c), dd, n);
  endtask

  // Collapse runs of done polls and compare with W0=1, W0=0, poll, reads 1..5
  function automatic int seq_errs();
    txn_t c[$];
    int   errs;
    foreach (log_q[i])
      if (!(!log_q[i].wr && log_q[i].addr == 6 && c.size() > 0 && !c[$].wr && c[$].addr == 6))
        c.push_back(log_q[i]);
    if (c.size() != 8) return 100 + c.size();
    errs = 0;
    if (!(c[0].wr && c[0].addr == 0 && c[0].data == 32'd1)) errs++;
    if (!(c[1].wr && c[1].addr == 0 && c[1].data == 32'd0)) errs++;
    if (c[2].wr || c[2].addr != 6) errs++;
    for (int a = 1; a <= 5; a++) begin
      logic [31:0] exp;
      exp = (a == 1) ? m_e : (a == 2) ? m_d : (a == 3) ? m_n : (a == 4) ? m_c : m_p;
      if (c[a+2].wr || c[a+2].addr != a || c[a+2].data !== exp) errs++;
    end
    return errs;
  endfunction

  function automatic int count_txn(input bit wr, input int addr, input bit match_data,
                                   input logic [31:0] data);
    int n = 0;
    foreach (log_q[i])
      if (log_q[i].wr == wr && log_q[i].addr == addr && (!match_data || log_q[i].data == data)) n++;
    return n;
  endfunction

  // Run one job; lat counts cycles from IDLE exit (1 = WR_SET) to job_done, -1 on time-out
  task automatic run_job(input int k, input bit stall, input bit hold_go,
                         output int lat, output logic busy1, output logic terr1,
                         output logic busy_after);
    done_poll = k;
    stall_en  = stall;
    log_q.delete();
    jd_cnt = 0;
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1;
    if (!hold_go) go = 1'b0;
    busy1 = busy; terr1 = timeout_err;
    lat = 1;
    while (!job_done && lat < 400) begin @(posedge clk); #1; lat++; end
    go = 1'b0;
    if (!job_done) lat = -1;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_e"}, e_out, m_e);
    chk({tag, "_d"}, d_out, m_d);
    chk({tag, "_n"}, n_out, m_n);
    chk({tag, "_c"}, cipher_out, m_c);
    chk({tag, "_p"}, plain_out, m_p);
  endtask

  initial begin
    int   lat, w, k;
    bit   st;
    logic b1, t1, ba;

    load_rsa();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_status", 32'({busy, job_done, timeout_err}), 32'd0);
    chk("rst_results", e_out | d_out | n_out | cipher_out | plain_out, 32'd0);
    chk("rst_bus", 32'({bus.avm_read, bus.avm_write}) | 32'(bus.avm_address) | bus.avm_writedata, 32'd0);
    reset = 1'b0;

    // Zero-wait job, done seen on poll 4
    run_job(4, 1'b0, 1'b0, lat, b1, t1, ba);
    chk("s1_latency", 32'(lat), 32'd12);
    chk("s1_busy_start", 32'(b1), 32'd1);
    chk("s1_busy_after", 32'(ba), 32'd0);
    chk("s1_job_done_pulses", 32'(jd_cnt), 32'd1);
    chk("s1_timeout_err", 32'(timeout_err), 32'd0);
    chk("s1_seq", 32'(seq_errs()), 32'd0);
    chk("s1_polls", 32'(count_txn(1'b0, 6, 1'b0, 32'd0)), 32'd4);
    chk("s1_e_const", e_out, 32'd17);
    chk("s1_d_const", d_out, 32'd1);
    chk("s1_n_const", n_out, 32'd15);
    chk("s1_c_const", cipher_out, 32'd5);
    chk("s1_p_const", plain_out, 32'd5);

    // 50% random stalls
    run_job(5, 1'b1, 1'b0, lat, b1, t1, ba);
    chk("s2_done", 32'(lat > 0), 32'd1);
    chk_results("s2");
    chk("s2_seq", 32'(seq_errs()), 32'd0);
    chk("s2_job_done_pulses", 32'(jd_cnt), 32'd1);
    chk("s2_stable_overlap", 32'(unstable_cnt + overlap_cnt), 32'd0);

    // Peripheral never signals done: timeout after TO polls, results untouched
    m_e = 32'hDEAD_0001; m_d = 32'hDEAD_0002; m_n = 32'hDEAD_0003;
    m_c = 32'hDEAD_0004; m_p = 32'hDEAD_0005;
    run_job(0, 1'b0, 1'b0, lat, b1, t1, ba);
    chk("s3_latency", 32'(lat), 32'(TO + 3));
    chk("s3_polls", 32'(count_txn(1'b0, 6, 1'b0, 32'd0)), 32'(TO));
    chk("s3_timeout_err", 32'(timeout_err), 32'd1);
    chk("s3_job_done_pulses", 32'(jd_cnt), 32'd1);
    chk("s3_busy_after", 32'(ba), 32'd0);
    chk("s3_results_kept", e_out ^ d_out ^ n_out ^ cipher_out ^ plain_out,
        32'd17 ^ 32'd1 ^ 32'd15 ^ 32'd5 ^ 32'd5);
    load_rsa();
    run_job(2, 1'b0, 1'b0, lat, b1, t1, ba);
    chk("s3_err_cleared_on_go", 32'(t1), 32'd0);
    chk("s3_retry_latency", 32'(lat), 32'd10);
    chk("s3_retry_err", 32'(timeout_err), 32'd0);

    // go held high through the whole job
    run_job(3, 1'b0, 1'b1, lat, b1, t1, ba);
    repeat (6) @(posedge clk);
    #1;
    chk("s4_single_start", 32'(count_txn(1'b1, 0, 1'b1, 32'd1)), 32'd1);
    chk("s4_job_done_pulses", 32'(jd_cnt), 32'd1);
    chk("s4_idle", 32'(busy), 32'd0);
    chk("s4_latency", 32'(lat), 32'd11);

    // Reset while RD_N is stalled
    stall_addr = 3;
    run_job_start: begin
      done_poll = 2; stall_en = 1'b0; log_q.delete();
      @(negedge clk); go = 1'b1;
      @(posedge clk); #1; go = 1'b0;
      w = 0;
      while (!(bus.avm_read && bus.avm_address == 5'd3) && w < 100) begin
        @(posedge clk); #1; w++;
      end
    end
    chk("s5_reached_rd_n", 32'(w < 100), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("s5_async_read_drop", 32'(bus.avm_read), 32'd0);
    chk("s5_async_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("s5_rst_results", e_out | d_out | n_out | cipher_out | plain_out, 32'd0);
    chk("s5_rst_bus", 32'({bus.avm_read, bus.avm_write, job_done, timeout_err})
        | 32'(bus.avm_address) | bus.avm_writedata, 32'd0);
    stall_addr = 31;
    @(negedge clk); reset = 1'b0;
    run_job(1, 1'b0, 1'b0, lat, b1, t1, ba);
    chk("s5_after_latency", 32'(lat), 32'd9);
    chk_results("s5_after");
    chk("s5_after_seq", 32'(seq_errs()), 32'd0);

    // Done arrives on the last allowed poll
    run_job(TO, 1'b0, 1'b0, lat, b1, t1, ba);
    chk("s6_latency", 32'(lat), 32'(TO + 8));
    chk("s6_timeout_err", 32'(timeout_err), 32'd0);
    chk("s6_seq", 32'(seq_errs()), 32'd0);

    // Random register contents, done position and stalls
    for (int j = 0; j < 6; j++) begin
      m_e = $urandom; m_d = $urandom; m_n = $urandom; m_c = $urandom; m_p = $urandom;
      k  = int'($urandom_range(1, 12));
      st = 1'($urandom_range(0, 1));
      run_job(k, st, 1'b0, lat, b1, t1, ba);
      if (!st) chk("rnd_latency", 32'(lat), 32'(k + 8));
      else     chk("rnd_done", 32'(lat > 0), 32'd1);
      chk_results("rnd");
      chk("rnd_seq", 32'(seq_errs()), 32'd0);
      chk("rnd_job_done_pulses", 32'(jd_cnt), 32'd1);
      chk("rnd_timeout_err", 32'(timeout_err), 32'd0);
    end

    chk("overlap_total", 32'(overlap_cnt), 32'd0);
    chk("unstable_total", 32'(unstable_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
